dp_sink_aux_reply_hpd: RTL

DP_SINK_AUX_REPLY_HPD -- requirements
Module: dp_sink_aux_reply_hpd

---
 rtl/dp_sink_pkg.sv | 23 ++
 rtl/dp_sink_sync_fifo.sv | 57 +++++
 rtl/dp_sink_aux_reply_hpd.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/dp_sink_pkg.sv
// Shared types and default parameters for the DP sink AUX reply / HPD block.
package dp_sink_pkg;

    localparam int unsigned DEF_DATA_W       = 8;
    localparam int unsigned DEF_FIFO_DEPTH   = 16;
    localparam int unsigned DEF_HPD_IRQ_CYC  = 8;
    localparam int unsigned DEF_HPD_LONG_CYC = 32;

    typedef enum logic [1:0] {
        R_IDLE = 2'd0,
        R_SEND = 2'd1,
        R_CHK  = 2'd2,
        R_GAP  = 2'd3
    } reply_state_e;

    typedef enum logic [1:0] {
        H_DISC = 2'd0,
        H_CONN = 2'd1,
        H_IRQ  = 2'd2,
        H_HOLD = 2'd3
    } hpd_state_e;

endpackage

// File: rtl/dp_sink_sync_fifo.sv
// Single-clock reply byte FIFO with combinational head read.
// A push while full is accepted only when a pop happens in the same cycle.
module dp_sink_sync_fifo
    import dp_sink_pkg::*;
#(
    parameter int unsigned DATA_W     = DEF_DATA_W,
    parameter int unsigned FIFO_DEPTH = DEF_FIFO_DEPTH
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         push,
    input  logic [DATA_W-1:0]            wr_data,
    input  logic                         pop,
    output logic [DATA_W-1:0]            rd_data,
    output logic [$clog2(FIFO_DEPTH):0]  level,
    output logic                         full,
    output logic                         empty
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned LW = AW + 1;

    logic [DATA_W-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [LW-1:0]     count;
    logic              do_push;
    logic              do_pop;

    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    // Pointer and occupancy tracking
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            if (do_push && !do_pop)      count <= count + LW'(1);
            else if (!do_push && do_pop) count <= count - LW'(1);
        end
    end

    // Storage array; contents need no reset
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wr_data;
    end

    assign rd_data = mem[rd_ptr];
    assign level   = count;
    assign full    = (count == LW'(FIFO_DEPTH));
    assign empty   = (count == '0);

endmodule

// File: rtl/dp_sink_aux_reply_hpd.sv
// DP sink AUX reply sequencer plus HPD line generator.
// Optional feature macro: DP_SINK_AUX_CHKSUM_EN appends an XOR checksum byte to each frame.
module dp_sink_aux_reply_hpd
    import dp_sink_pkg::*;
#(
    parameter int unsigned DATA_W       = DEF_DATA_W,
    parameter int unsigned FIFO_DEPTH   = DEF_FIFO_DEPTH,
    parameter int unsigned HPD_IRQ_CYC  = DEF_HPD_IRQ_CYC,
    parameter int unsigned HPD_LONG_CYC = DEF_HPD_LONG_CYC
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         wr_vld,
    input  logic [DATA_W-1:0]            wr_data,
    output logic                         wr_rdy,
    input  logic                         reply_go,
    input  logic [$clog2(FIFO_DEPTH):0]  reply_len,
    output logic [DATA_W-1:0]            AUX_IN_OUT,
    output logic                         PHY_START_STOP,
    input  logic                         hpd_connect,
    input  logic                         hpd_irq_req,
    output logic                         HPD_Signal,
    output logic                         busy,
    output logic [$clog2(FIFO_DEPTH):0]  fifo_level,
    output logic                         err_reject
);

    localparam int unsigned LW   = $clog2(FIFO_DEPTH) + 1;
    localparam int unsigned HMAX = (HPD_LONG_CYC > HPD_IRQ_CYC) ? HPD_LONG_CYC : HPD_IRQ_CYC;
    localparam int unsigned HW   = $clog2(HMAX + 1);

    logic [DATA_W-1:0] fifo_rd_data;
    logic              fifo_full;
    logic              fifo_empty;
    logic              pop_c;

    dp_sink_sync_fifo #(
        .DATA_W     (DATA_W),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push    (wr_vld),
        .wr_data (wr_data),
        .pop     (pop_c),
        .rd_data (fifo_rd_data),
        .level   (fifo_level),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    assign wr_rdy = !fifo_full;

    reply_state_e      r_state, r_state_nxt;
    logic [LW-1:0]     cnt, cnt_nxt;
    logic [DATA_W-1:0] aux_nxt;
    logic              phy_nxt, busy_nxt, err_nxt;
`ifdef DP_SINK_AUX_CHKSUM_EN
    logic [DATA_W-1:0] chk, chk_nxt;
`endif

    // Reply sequencer: next state, pop request and next registered outputs
    always_comb begin
        r_state_nxt = r_state;
        cnt_nxt     = cnt;
        aux_nxt     = '0;
        phy_nxt     = 1'b0;
        busy_nxt    = 1'b0;
        err_nxt     = 1'b0;
        pop_c       = 1'b0;
`ifdef DP_SINK_AUX_CHKSUM_EN
        chk_nxt     = chk;
`endif
        case (r_state)
            R_IDLE: begin
                if (reply_go) begin
                    if (reply_len != '0 && reply_len <= fifo_level && !fifo_empty) begin
                        pop_c       = 1'b1;
                        aux_nxt     = fifo_rd_data;
                        phy_nxt     = 1'b1;
                        busy_nxt    = 1'b1;
                        cnt_nxt     = reply_len - LW'(1);
                        r_state_nxt = R_SEND;
`ifdef DP_SINK_AUX_CHKSUM_EN
                        chk_nxt     = fifo_rd_data;
`endif
                    end else begin
                        err_nxt = 1'b1;
                    end
                end
            end
            R_SEND: begin
                busy_nxt = 1'b1;
                if (cnt != '0) begin
                    pop_c   = 1'b1;
                    aux_nxt = fifo_rd_data;
                    phy_nxt = 1'b1;
                    cnt_nxt = cnt - LW'(1);
`ifdef DP_SINK_AUX_CHKSUM_EN
                    chk_nxt = chk ^ fifo_rd_data;
`endif
                end else begin
`ifdef DP_SINK_AUX_CHKSUM_EN
                    aux_nxt     = chk;
                    phy_nxt     = 1'b1;
                    r_state_nxt = R_CHK;
`else
                    r_state_nxt = R_GAP;
`endif
                end
            end
            R_CHK: begin
                busy_nxt    = 1'b1;
                r_state_nxt = R_GAP;
            end
            R_GAP: begin
                r_state_nxt = R_IDLE;
            end
        endcase
    end

    // Reply sequencer state and output registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state        <= R_IDLE;
            cnt            <= '0;
            AUX_IN_OUT     <= '0;
            PHY_START_STOP <= 1'b0;
            busy           <= 1'b0;
            err_reject     <= 1'b0;
`ifdef DP_SINK_AUX_CHKSUM_EN
            chk            <= '0;
`endif
        end else begin
            r_state        <= r_state_nxt;
            cnt            <= cnt_nxt;
            AUX_IN_OUT     <= aux_nxt;
            PHY_START_STOP <= phy_nxt;
            busy           <= busy_nxt;
            err_reject     <= err_nxt;
`ifdef DP_SINK_AUX_CHKSUM_EN
            chk            <= chk_nxt;
`endif
        end
    end

    hpd_state_e    h_state, h_nxt;
    logic [HW-1:0] hcnt, hcnt_nxt;
    logic          hpd_nxt;

    // HPD generator: disconnect beats IRQ; IRQ and HOLD are fixed-length low windows
    always_comb begin
        h_nxt    = h_state;
        hcnt_nxt = hcnt;
        case (h_state)
            H_DISC: begin
                if (hpd_connect) h_nxt = H_CONN;
            end
            H_CONN: begin
                if (!hpd_connect) begin
                    h_nxt    = H_HOLD;
                    hcnt_nxt = HW'(HPD_LONG_CYC - 1);
                end else if (hpd_irq_req) begin
                    h_nxt    = H_IRQ;
                    hcnt_nxt = HW'(HPD_IRQ_CYC - 1);
                end
            end
            H_IRQ: begin
                if (hcnt == '0) begin
                    if (hpd_connect) begin
                        h_nxt = H_CONN;
                    end else begin
                        h_nxt    = H_HOLD;
                        hcnt_nxt = HW'(HPD_LONG_CYC - 1);
                    end
                end else begin
                    hcnt_nxt = hcnt - HW'(1);
                end
            end
            H_HOLD: begin
                if (hcnt == '0) h_nxt = H_DISC;
                else            hcnt_nxt = hcnt - HW'(1);
            end
        endcase
        hpd_nxt = (h_nxt == H_CONN);
    end

    // HPD state and output registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            h_state    <= H_DISC;
            hcnt       <= '0;
            HPD_Signal <= 1'b0;
        end else begin
            h_state    <= h_nxt;
            hcnt       <= hcnt_nxt;
            HPD_Signal <= hpd_nxt;
        end
    end

endmodule
